// File: rtl/pipe_issue_arbiter_pkg.sv
// Shared types, constants and the per-stage transfer function for the
// two-requester issue arbiter.
package pipe_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned F_MAX_W = 64;

    typedef logic req_id_t;

    localparam req_id_t RR_RESET = 1'b0;

    // 2x+1 at the widest supported width; the low bits of the result depend only
    // on the low bits of x, so callers truncate to their own data width.
    function automatic logic [F_MAX_W-1:0] stage_f(input logic [F_MAX_W-1:0] x);
        return {x[F_MAX_W-2:0], 1'b1};
    endfunction

endpackage

// File: rtl/pipe_issue_arbiter_if.sv
// Requester and result handshake bundle for pipe_issue_arbiter.
interface pipe_issue_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    logic                   req0_valid;
    logic                   req0_ready;
    logic [WIDTH-1:0]       req0_data;
    logic                   req1_valid;
    logic                   req1_ready;
    logic [WIDTH-1:0]       req1_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    pipe_arb_pkg::req_id_t  out_id;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/pipe_issue_arbiter_stage.sv
// One pipeline stage: valid/id/data registers with hold and valid-only clear.
module pipe_stage_reg
    import pipe_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             clear,
    input  logic             nxt_valid,
    input  req_id_t          nxt_id,
    input  logic [WIDTH-1:0] nxt_data,
    output logic             valid,
    output req_id_t          id,
    output logic [WIDTH-1:0] data
);

    // clear beats hold so a flush empties a stalled pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            id    <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (!hold) begin
            valid <= nxt_valid;
            id    <= nxt_id;
            data  <= nxt_data;
        end
    end

endmodule

// File: rtl/pipe_issue_arbiter.sv
// Round-robin, credit-limited issue of two requesters into a shared
// DEPTH-stage 2x+1 pipeline with a single backpressured result port.
module pipe_issue_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned DEPTH        = 3,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    pipe_issue_arbiter_if.slave               bus,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight0,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight1
);

    localparam int unsigned OCC_W = $clog2(DEPTH+1);
    localparam int unsigned CW    = $clog2(MAX_INFLIGHT+1);

    function automatic logic [WIDTH-1:0] f_w(input logic [WIDTH-1:0] x);
        logic [F_MAX_W-1:0] r;
        r = stage_f(F_MAX_W'(x));
        return r[WIDTH-1:0];
    endfunction

    logic [DEPTH-1:0] st_valid;
    logic [DEPTH-1:0] nxt_valid;
    req_id_t          st_id    [DEPTH];
    req_id_t          nxt_id   [DEPTH];
    logic [WIDTH-1:0] st_data  [DEPTH];
    logic [WIDTH-1:0] nxt_data [DEPTH];

    logic             stall;
    logic             hs;
    logic             elig0, elig1;
    logic             grant0, grant1;
    logic             acc0, acc1;
    req_id_t          rr_ptr;
    logic [CW-1:0]    cnt0, cnt1;
    logic [OCC_W-1:0] occ;

    assign bus.out_valid = st_valid[DEPTH-1];
    assign bus.out_id    = st_id[DEPTH-1];
    assign bus.out_data  = st_data[DEPTH-1];

    assign stall = bus.out_valid & ~bus.out_ready;
    assign hs    = bus.out_valid & bus.out_ready;

    always_comb begin
        elig0  = bus.req0_valid & (cnt0 < CW'(MAX_INFLIGHT));
        elig1  = bus.req1_valid & (cnt1 < CW'(MAX_INFLIGHT));
        grant0 = elig0 & (~elig1 | (rr_ptr == 1'b0));
        grant1 = elig1 & (~elig0 | (rr_ptr == 1'b1));
        acc0   = grant0 & ~stall & ~flush & ~rst;
        acc1   = grant1 & ~stall & ~flush & ~rst;
    end

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;

    always_comb begin
        nxt_valid[0] = acc0 | acc1;
        nxt_id[0]    = acc1;
        nxt_data[0]  = f_w(acc1 ? bus.req1_data : bus.req0_data);
        for (int unsigned k = 1; k < DEPTH; k++) begin
            nxt_valid[k] = st_valid[k-1];
            nxt_id[k]    = st_id[k-1];
            nxt_data[k]  = f_w(st_data[k-1]);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage_reg #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .hold      (stall),
            .clear     (flush),
            .nxt_valid (nxt_valid[k]),
            .nxt_id    (nxt_id[k]),
            .nxt_data  (nxt_data[k]),
            .valid     (st_valid[k]),
            .id        (st_id[k]),
            .data      (st_data[k])
        );
    end

    // accept and delivery for the same requester in one cycle cancel out
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= cnt0 + CW'(acc0) - CW'(hs & (bus.out_id == 1'b0));
            cnt1 <= cnt1 + CW'(acc1) - CW'(hs & (bus.out_id == 1'b1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= RR_RESET;
        end else if (acc0) begin
            rr_ptr <= 1'b1;
        end else if (acc1) begin
            rr_ptr <= 1'b0;
        end
    end

    always_comb begin
        occ = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            occ = occ + OCC_W'(st_valid[k]);
        end
    end

    assign occupancy = occ;
    assign inflight0 = cnt0;
    assign inflight1 = cnt1;

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Directed bench for pipe_issue_arbiter at WIDTH=4, DEPTH=3, MAX_INFLIGHT=2.
module tb_pipe_issue_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] occupancy;
    logic [1:0] inflight0;
    logic [1:0] inflight1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_issue_arbiter_if #(.WIDTH(4)) bus ();

    pipe_issue_arbiter #(
        .WIDTH        (4),
        .DEPTH        (3),
        .MAX_INFLIGHT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy),
        .inflight0 (inflight0),
        .inflight1 (inflight1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [3:0] d0,
                         input logic v1, input logic [3:0] d1);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int e0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        tick();

        // ready is held low throughout reset even with both requesters valid
        drive(1'b1, 4'd5, 1'b1, 4'd0);
        chk("rst_ready0", 32'(bus.req0_ready), 0);
        chk("rst_ready1", 32'(bus.req1_ready), 0);
        tick();
        rst = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  32'(bus.out_data), 0);
        chk("rst_out_id",    32'(bus.out_id), 0);
        chk("rst_occ",       32'(occupancy), 0);
        chk("rst_infl0",     32'(inflight0), 0);
        chk("rst_infl1",     32'(inflight1), 0);

        // single issue: f^3(5) = 47 mod 16 = 15
        drive(1'b1, 4'd5, 1'b0, 4'd0);
        chk("si_ready0", 32'(bus.req0_ready), 1);
        chk("si_infl0_0", 32'(inflight0), 0);
        tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        chk("si_infl0_1", 32'(inflight0), 1);
        chk("si_occ1", 32'(occupancy), 1);
        chk("si_valid_c1", 32'(bus.out_valid), 0);
        tick();
        chk("si_valid_c2", 32'(bus.out_valid), 0);
        tick();
        chk("si_valid_c3", 32'(bus.out_valid), 1);
        chk("si_data", 32'(bus.out_data), 15);
        chk("si_id", 32'(bus.out_id), 0);
        chk("si_infl0_held", 32'(inflight0), 1);
        tick();
        chk("si_infl0_done", 32'(inflight0), 0);
        chk("si_valid_done", 32'(bus.out_valid), 0);

        // round robin from a freshly reset pointer: f^3(0)=7, f^3(1)=15
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'd0, 1'b1, 4'd1);
            e0 = (i % 2 == 0) ? 1 : 0;
            chk("rr_ready0", 32'(bus.req0_ready), 32'(e0));
            chk("rr_ready1", 32'(bus.req1_ready), 32'(1 - e0));
            tick();
            if (i >= 2) begin
                chk("rr_out_valid", 32'(bus.out_valid), 1);
                chk("rr_out_id", 32'(bus.out_id), 32'(i % 2));
                chk("rr_out_data", 32'(bus.out_data), (i % 2 == 0) ? 32'd7 : 32'd15);
            end
        end
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("rr_drain_occ", 32'(occupancy), 0);
        chk("rr_drain_infl0", 32'(inflight0), 0);
        chk("rr_drain_infl1", 32'(inflight1), 0);

        // credit limit with the consumer stalled: f^3(2) = 23 mod 16 = 7
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd2, 1'b0, 4'd0);
        chk("cr_ready0_a", 32'(bus.req0_ready), 1);
        tick();
        chk("cr_ready0_b", 32'(bus.req0_ready), 1);
        chk("cr_infl0_b", 32'(inflight0), 1);
        tick();
        chk("cr_ready0_c", 32'(bus.req0_ready), 0);
        chk("cr_infl0_c", 32'(inflight0), 2);
        tick();

        // backpressure: head result parked, req1 eligible but blocked by the stall
        drive(1'b1, 4'd2, 1'b1, 4'd0);
        for (int j = 0; j < 4; j++) begin
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_data", 32'(bus.out_data), 7);
            chk("bp_id", 32'(bus.out_id), 0);
            chk("bp_occ", 32'(occupancy), 2);
            chk("bp_ready0", 32'(bus.req0_ready), 0);
            chk("bp_ready1", 32'(bus.req1_ready), 0);
            chk("bp_infl0", 32'(inflight0), 2);
            tick();
        end

        bus.out_ready = 1'b1;
        drive(1'b0, 4'd2, 1'b0, 4'd0);
        tick();
        chk("dr_infl0", 32'(inflight0), 1);
        chk("dr_valid", 32'(bus.out_valid), 1);
        chk("dr_data", 32'(bus.out_data), 7);
        drive(1'b1, 4'd2, 1'b0, 4'd0);
        chk("dr_ready0", 32'(bus.req0_ready), 1);
        tick();
        chk("dr_infl0_same", 32'(inflight0), 1);
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("dr_infl0_end", 32'(inflight0), 0);
        chk("dr_occ_end", 32'(occupancy), 0);

        // pointer survived the stall: last accept was req0, so req1 wins now
        drive(1'b1, 4'd0, 1'b1, 4'd1);
        chk("ptr_ready1", 32'(bus.req1_ready), 1);
        chk("ptr_ready0", 32'(bus.req0_ready), 0);
        tick();
        chk("fill_ready0", 32'(bus.req0_ready), 1);
        tick();
        chk("fill_ready1", 32'(bus.req1_ready), 1);
        tick();

        // flush with a full pipeline and both requesters valid
        flush = 1'b1;
        #1;
        chk("fl_ready0", 32'(bus.req0_ready), 0);
        chk("fl_ready1", 32'(bus.req1_ready), 0);
        chk("fl_occ", 32'(occupancy), 3);
        chk("fl_infl0", 32'(inflight0), 1);
        chk("fl_infl1", 32'(inflight1), 2);
        chk("fl_out_id", 32'(bus.out_id), 1);
        chk("fl_out_data", 32'(bus.out_data), 15);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_occ_after", 32'(occupancy), 0);
        chk("fl_infl0_after", 32'(inflight0), 0);
        chk("fl_infl1_after", 32'(inflight1), 0);
        chk("fl_valid_after", 32'(bus.out_valid), 0);
        chk("fl_ptr_ready0", 32'(bus.req0_ready), 1);
        chk("fl_ptr_ready1", 32'(bus.req1_ready), 0);
        tick();
        chk("mr_ready1", 32'(bus.req1_ready), 1);
        tick();
        chk("mr_ready0", 32'(bus.req0_ready), 1);
        tick();
        chk("mr_occ", 32'(occupancy), 3);

        // reset with three results in flight
        rst = 1'b1;
        #1;
        chk("mr_rst_ready0", 32'(bus.req0_ready), 0);
        chk("mr_rst_ready1", 32'(bus.req1_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_occ_after", 32'(occupancy), 0);
        chk("mr_valid_after", 32'(bus.out_valid), 0);
        chk("mr_data_after", 32'(bus.out_data), 0);
        chk("mr_id_after", 32'(bus.out_id), 0);
        chk("mr_infl0_after", 32'(inflight0), 0);
        chk("mr_infl1_after", 32'(inflight1), 0);
        chk("mr_ptr_ready0", 32'(bus.req0_ready), 1);
        chk("mr_ptr_ready1", 32'(bus.req1_ready), 0);
        tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_issue_arbiter.md
Name: pipe_issue_arbiter

Overview:
- Shares one DEPTH-stage compute pipeline between two requesters.
- Each stage applies f(x) = (2*x + 1) mod 2^WIDTH.
- Round-robin arbitration at the pipeline head, per-requester in-flight credit limits, and a single output port with valid/ready backpressure.
- Sits between the requester front-ends and the result consumer. It owns the stage enables, valid tags and requester IDs for the pipeline.

Parameters:
- WIDTH, 4, data width of requests, stages and result.
- DEPTH, 3, number of pipeline stages (>=1).
- MAX_INFLIGHT, 2, maximum accepted-but-undelivered transactions per requester (>=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous pipeline/credit clear.
- req0_valid  in  1  requester 0 has data.
- req0_data  in  WIDTH  requester 0 operand.
- req0_ready  out  1  requester 0 accepted this cycle (when valid).
- req1_valid  in  1  requester 1 has data.
- req1_data  in  WIDTH  requester 1 operand.
- req1_ready  out  1  requester 1 accepted this cycle (when valid).
- out_valid  out  1  result at last stage is valid.
- out_ready  in  1  consumer takes result.
- out_data  out  WIDTH  f applied DEPTH times to the accepted operand.
- out_id  out  1  requester that issued the result.
- occupancy  out  $clog2(DEPTH+1)  count of valid stages.
- inflight0  out  $clog2(MAX_INFLIGHT+1)  requester 0 outstanding count.
- inflight1  out  $clog2(MAX_INFLIGHT+1)  requester 1 outstanding count.

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. After reset:
  - all stage valids = 0, stage data = 0, stage ids = 0;
  - rr pointer = 0 (requester 0 preferred);
  - inflight0/1 = 0, occupancy = 0;
  - out_valid = 0, out_data = 0, out_id = 0.
  - req*_ready = 0 while rst is high.
- Stall: stall = out_valid & ~out_ready.
  - On stall all stages hold and no request is accepted.
  - Otherwise every stage advances one position; bubbles advance too (no bubble collapse).
- Eligibility: elig_i = req_i_valid & (inflight_i < MAX_INFLIGHT).
- Grant:
  - If neither is eligible, no grant.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the requester at the rr pointer.
  - On every accepted grant to i, the pointer moves to 1-i. Without an accept, the pointer holds.
- Ready: req_i_ready = grant_i & ~stall & ~flush & ~rst.
  - Ready may depend on both valids, combinationally.
  - Requesters must not make valid depend on ready.
- Stage 0 input:
  - On accept: valid = 1, id = i, data = f(req_i_data).
  - On no accept (not stalled): valid = 0.
- Stage k (k >= 1), when not stalled: data <= f(stage k-1 data); valid and id copied from stage k-1.
- Outputs: out_* = last stage. f wraps modulo 2^WIDTH.
- Latency: the result is visible on out_valid exactly DEPTH cycles after the accept cycle, absent stalls. Each stall cycle adds one cycle.
- Throughput: one accept per cycle.
- inflight_i:
  - +1 on accept from i.
  - -1 on an output handshake (out_valid & out_ready) with out_id = i.
  - Accept and handshake for the same i in one cycle: unchanged.
  - Never exceeds MAX_INFLIGHT or underflows.
- occupancy equals the popcount of stage valids, updated with the same timing as the stages.
- flush:
  - Next cycle all stage valids = 0, inflight0/1 = 0, rr pointer unchanged.
  - No accept in the flush cycle.
  - If out_valid & out_ready hold in the flush cycle, that handshake completes (consumer sees it) but the counter clear wins.
  - Data/id registers need not clear.
- rst has priority over flush.
- rst mid-operation: all in-flight results are discarded with no output handshake.

Decomposition:
- Package pipe_arb_pkg:
  - function stage_f (2x+1 at WIDTH);
  - requester-id typedef (1 bit);
  - constants NUM_REQ = 2 and RR_RESET = 0.
- Sub-module pipe_stage_reg:
  - one stage of valid/id/data registers;
  - inputs: hold enable, clear (valid only), next valid/id/data;
  - instantiated DEPTH times via generate.
- Arbiter, credit counters and stall logic stay in the top module.

Test Plan:
- Single issue:
  - Stimulus: after reset, req0 sends 5 with out_ready = 1.
  - Response: req0_ready = 1 on the accept cycle; 3 cycles later out_valid = 1, out_data = 15, out_id = 0; inflight0 goes 0→1→0.
- Round-robin:
  - Stimulus: req0 and req1 both valid continuously, data 0 and 1.
  - Response: grants alternate 0,1,0,1. Outputs 7 (id 0) and 15 (id 1) (f^3(1) = 15 at WIDTH 4) alternate every cycle.
- Credit limit:
  - Stimulus: out_ready = 0, req0 always valid, req1 idle.
  - Response: exactly 2 accepts, then req0_ready = 0; inflight0 = 2. Raising out_ready drains the results and re-enables req0.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 4 cycles while out_valid = 1.
  - Response: out_data/out_id are stable and occupancy is constant. No accepts occur; the rr pointer is unchanged.
- Flush:
  - Stimulus: assert flush with occupancy = 3 and both requesters valid.
  - Response: no accept that cycle. Next cycle occupancy = 0, inflight0 = inflight1 = 0, out_valid = 0.
- Reset mid-stream:
  - Stimulus: assert rst while 3 results are in flight.
  - Response: next cycle all outputs are at their reset values, and req*_ready = 0 during rst.
